heartbeat_monitor: RTL and testbench
====================================

HEARTBEAT_MONITOR -- requirements
Module: heartbeat_monitor

Interface
REQ-001 Parameter N, default 8: expected heartbeat period is PERIOD = 2^N clk cycles.
REQ-002 Parameter TOL, default 2: allowed period deviation in cycles; legal range 0 <= TOL < PERIOD/2.
REQ-003 Parameter MAXMISS, default 3: consecutive bad events that cause FAULT; legal range 1..255.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  monitor enable; low forces IDLE.
REQ-007 hb_in  input  1  heartbeat pulse, one clk cycle high per period, synchronous to clk.
REQ-008 clear  input  1  one-cycle request clearing fault, miss_cnt and sticky flags.
REQ-009 alive  output  1  high while in LOCK.
REQ-010 fault  output  1  high while in FAULT.
REQ-011 early  output  1  sticky: an early pulse has been seen since last clear/reset.
REQ-012 late  output  1  sticky: a timeout has occurred since last clear/reset.
REQ-013 miss_cnt  output  8  total bad events since last clear/reset, saturating at 255.
REQ-014 period  output  N+1  last measured pulse-to-pulse interval in cycles.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 Interval counter cnt (N+1 bits) SHALL load 0 on any cycle with hb_in=1, on a timeout, and in IDLE; otherwise increment by 1, saturating at all-ones.
REQ-017 On a cycle with hb_in=1 the measured interval SHALL be cnt+1; period SHALL take that value on the next edge (pulses exactly PERIOD apart give period=PERIOD).
REQ-018 Good pulse: interval in [PERIOD-TOL, PERIOD+TOL]; early pulse: interval < PERIOD-TOL.
REQ-019 Timeout: hb_in=0 while cnt = PERIOD+TOL-1; a pulse in that cycle is good, not a timeout.
REQ-020 States: IDLE, SYNC, LOCK, FAULT; enable=0 SHALL force IDLE next edge from any state.
REQ-021 IDLE -> SYNC when enable=1; cnt starts counting from 0.
REQ-022 SYNC: any pulse -> LOCK, no interval check; timeout -> bad event, stay SYNC.
REQ-023 LOCK: good pulse -> stay, consecutive-bad counter cleared; early pulse or timeout -> bad event, go SYNC.
REQ-024 Each bad event SHALL increment miss_cnt (saturating) and consecutive-bad counter, and set early or late accordingly.
REQ-025 When consecutive-bad counter reaches MAXMISS the state SHALL go FAULT instead of SYNC; FAULT ignores hb_in.
REQ-026 clear in FAULT with enable=1 -> SYNC; clear in any state zeroes miss_cnt, early, late and consecutive-bad counter.
REQ-027 clear and a bad event in the same cycle: clear wins; event not recorded.
REQ-028 alive rises the edge after the first pulse sampled in SYNC.

Reset
REQ-029 reset SHALL force state IDLE, cnt=0, alive=0, fault=0, early=0, late=0, miss_cnt=0, period=0 asynchronously; release mid-period restarts in IDLE.
REQ-030 Reset asserted mid-operation SHALL discard all measurement history.

Structure
REQ-031 State encoding and the 8-bit miss_cnt width SHALL live in shared package heartbeat_pkg.
REQ-032 Interval counter with saturation and timeout compare SHALL be sub-module hb_interval_cnt; FSM and flags in heartbeat_monitor.

Verification (N=8, TOL=2, MAXMISS=3)
REQ-033 Pulses every 256 cycles after enable -> alive=1 the edge after first pulse, period=256, miss_cnt=0.
REQ-034 In LOCK, pulse spaced 253 cycles -> early=1, miss_cnt=1, alive=0, state SYNC; next pulse relocks.
REQ-035 In LOCK, pulse at 258 -> good; no pulse by interval 258 -> late=1, miss_cnt=1, state SYNC.
REQ-036 Stop pulses after lock -> three timeouts 258 cycles apart -> fault=1, miss_cnt=3; clear -> SYNC, miss_cnt=0.
REQ-037 clear coincident with timeout -> miss_cnt=0, late=0; enable=0 in LOCK -> IDLE next edge, alive=0.
REQ-038 reset asserted mid-LOCK -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/heartbeat_pkg.sv
// Shared types for the heartbeat monitor: FSM state encoding and miss-counter width.
// Pure declarations; no latency, no backpressure.
package heartbeat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_LOCK  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam int MISS_W = 8;
  typedef logic [MISS_W-1:0] miss_t;

  function automatic miss_t sat_inc(input miss_t v);
    return (v == '1) ? v : v + miss_t'(1);
  endfunction

endpackage

// File: rtl/heartbeat_monitor_if.sv
// Heartbeat monitor control/status bundle; master drives enable/hb_in/clear, slave reports status.
// Wires only; no latency, no backpressure.
interface heartbeat_monitor_if
  import heartbeat_pkg::*;
#(
  parameter int N = 8
);
  logic       enable;
  logic       hb_in;
  logic       clear;
  logic       alive;
  logic       fault;
  logic       early;
  logic       late;
  miss_t      miss_cnt;
  logic [N:0] period;

  modport master (
    output enable, hb_in, clear,
    input  alive, fault, early, late, miss_cnt, period
  );

  modport slave (
    input  enable, hb_in, clear,
    output alive, fault, early, late, miss_cnt, period
  );
endinterface

// File: rtl/hb_interval_cnt.sv
// Pulse-to-pulse interval counter, saturating, with timeout flag at PERIOD+TOL-1.
// Count registered; timeout is combinational from the count; no backpressure.
module hb_interval_cnt #(
  parameter int N   = 8,
  parameter int TOL = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_hold,
  input  logic       i_hb,
  output logic [N:0] o_cnt,
  output logic       o_timeout
);
  localparam logic [N:0] TMO_VAL = (N+1)'((1 << N) + TOL - 1);

  logic [N:0] r_cnt;
  logic       w_timeout;

  // A pulse landing on the last legal count is good, so it masks the timeout.
  assign w_timeout = !i_hb && (r_cnt == TMO_VAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_hold || i_hb || w_timeout) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + (N+1)'(1);
    end
  end

  assign o_cnt     = r_cnt;
  assign o_timeout = w_timeout;
endmodule

// File: rtl/heartbeat_monitor.sv
// Heartbeat period monitor: IDLE/SYNC/LOCK/FAULT FSM, sticky early/late flags, miss counter.
// All status registered, one cycle after the sampled pulse/timeout; no backpressure.
module heartbeat_monitor
  import heartbeat_pkg::*;
#(
  parameter int N       = 8,
  parameter int TOL     = 2,
  parameter int MAXMISS = 3
) (
  input  logic               clk,
  input  logic               reset,
  heartbeat_monitor_if.slave bus
);
  localparam int         PERIOD    = 1 << N;
  localparam logic [N:0] EARLY_LIM = (N+1)'(PERIOD - TOL - 1);
  localparam miss_t      MAX_BAD   = miss_t'(MAXMISS);

  state_t     r_state, w_state_nxt;
  miss_t      r_consec, w_consec_nxt, w_consec_inc;
  miss_t      r_miss, w_miss_nxt;
  logic       r_early, w_early_nxt;
  logic       r_late, w_late_nxt;
  logic       r_alive, r_fault;
  logic [N:0] r_period;

  logic [N:0] w_cnt;
  logic       w_timeout;
  logic       w_watch;
  logic       w_early_hb;
  logic       w_bad;
  logic       w_rec;

  hb_interval_cnt #(
    .N   (N),
    .TOL (TOL)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_hold    (r_state == ST_IDLE),
    .i_hb      (bus.hb_in),
    .o_cnt     (w_cnt),
    .o_timeout (w_timeout)
  );

  // interval = cnt+1, so "interval < PERIOD-TOL" is "cnt < PERIOD-TOL-1"
  assign w_watch    = (r_state == ST_SYNC) || (r_state == ST_LOCK);
  assign w_early_hb = bus.hb_in && (w_cnt < EARLY_LIM);
  assign w_bad      = ((r_state == ST_LOCK) && (w_early_hb || w_timeout)) ||
                      ((r_state == ST_SYNC) && w_timeout);
  assign w_rec      = w_bad && bus.enable && !bus.clear;
  assign w_consec_inc = sat_inc(r_consec);

  always_comb begin
    w_state_nxt  = r_state;
    w_consec_nxt = r_consec;
    w_miss_nxt   = r_miss;
    w_early_nxt  = r_early;
    w_late_nxt   = r_late;

    if (w_rec) begin
      w_consec_nxt = w_consec_inc;
      w_miss_nxt   = sat_inc(r_miss);
      if (bus.hb_in) w_early_nxt = 1'b1;
      else           w_late_nxt  = 1'b1;
    end

    case (r_state)
      ST_IDLE:  w_state_nxt = ST_SYNC;
      ST_SYNC: begin
        if (bus.hb_in)                               w_state_nxt = ST_LOCK;
        else if (w_rec && (w_consec_inc >= MAX_BAD)) w_state_nxt = ST_FAULT;
      end
      ST_LOCK: begin
        if (w_bad) begin
          w_state_nxt = (w_rec && (w_consec_inc >= MAX_BAD)) ? ST_FAULT : ST_SYNC;
        end else if (bus.hb_in) begin
          w_consec_nxt = '0;
        end
      end
      ST_FAULT: if (bus.clear) w_state_nxt = ST_SYNC;
      default:  w_state_nxt = ST_IDLE;
    endcase

    // A coincident clear overrides whatever the event above recorded.
    if (bus.clear) begin
      w_consec_nxt = '0;
      w_miss_nxt   = '0;
      w_early_nxt  = 1'b0;
      w_late_nxt   = 1'b0;
    end

    if (!bus.enable) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_consec <= '0;
      r_miss   <= '0;
      r_early  <= 1'b0;
      r_late   <= 1'b0;
      r_alive  <= 1'b0;
      r_fault  <= 1'b0;
      r_period <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_consec <= w_consec_nxt;
      r_miss   <= w_miss_nxt;
      r_early  <= w_early_nxt;
      r_late   <= w_late_nxt;
      r_alive  <= (w_state_nxt == ST_LOCK);
      r_fault  <= (w_state_nxt == ST_FAULT);
      if (bus.hb_in && w_watch) r_period <= w_cnt + (N+1)'(1);
    end
  end

  assign bus.alive    = r_alive;
  assign bus.fault    = r_fault;
  assign bus.early    = r_early;
  assign bus.late     = r_late;
  assign bus.miss_cnt = r_miss;
  assign bus.period   = r_period;
endmodule

// File: tb/tb_heartbeat_monitor.sv
// Self-checking bench for heartbeat_monitor: directed scenarios plus randomized pulse spacing
// against a cycle-level reference model of the monitoring rules.
module tb_heartbeat_monitor;
  localparam int N       = 8;
  localparam int TOL     = 2;
  localparam int MAXMISS = 3;
  localparam int P       = 1 << N;
  localparam int VW      = 4 + 8 + N + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  heartbeat_monitor_if #(.N(N)) bus ();

  heartbeat_monitor #(
    .N       (N),
    .TOL     (TOL),
    .MAXMISS (MAXMISS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: time since last counter restart, and mode flags.
  int m_cnt, m_consec, m_miss, m_period;
  bit m_idle, m_lock, m_fault, m_early, m_late;

  function automatic void model_reset();
    m_cnt = 0; m_consec = 0; m_miss = 0; m_period = 0;
    m_idle = 1; m_lock = 0; m_fault = 0; m_early = 0; m_late = 0;
  endfunction

  function automatic void model_step(bit en, bit hb, bit clr);
    int iv;
    bit tmo, watching, bad, rec, was_idle, was_fault;
    iv        = m_cnt + 1;
    tmo       = !hb && (m_cnt == P + TOL - 1);
    watching  = !m_idle && !m_fault;
    bad       = watching && (tmo || (m_lock && hb && iv < P - TOL));
    rec       = bad && en && !clr;
    was_idle  = m_idle;
    was_fault = m_fault;

    if (m_idle || hb || tmo) m_cnt = 0;
    else if (m_cnt < 2 * P - 1) m_cnt = m_cnt + 1;
    if (watching && hb) m_period = iv;

    if (rec) begin
      m_consec = m_consec + 1;
      if (m_miss < 255) m_miss = m_miss + 1;
      if (hb) m_early = 1; else m_late = 1;
    end else if (m_lock && hb && !bad) begin
      m_consec = 0;
    end
    if (clr) begin m_consec = 0; m_miss = 0; m_early = 0; m_late = 0; end

    if (!en) begin
      m_idle = 1; m_lock = 0; m_fault = 0;
    end else if (was_idle) begin
      m_idle = 0;
    end else if (was_fault) begin
      if (clr) m_fault = 0;
    end else if (bad) begin
      m_lock  = 0;
      m_fault = rec && (m_consec >= MAXMISS);
    end else if (hb) begin
      m_lock = 1;
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [7:0] mc;
    logic [N:0] pd;
    mc = m_miss[7:0];
    pd = m_period[N:0];
    return {m_lock, m_fault, m_early, m_late, mc, pd};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.alive, bus.fault, bus.early, bus.late, bus.miss_cnt, bus.period};
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic tick(input bit en, input bit hb, input bit clr);
    bus.enable = en;
    bus.hb_in  = hb;
    bus.clear  = clr;
    @(posedge clk);
    model_step(en, hb, clr);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0);
  endtask

  // Pulse exactly g cycles after the previous pulse.
  task automatic gap(input int g);
    idle_ticks(g - 1);
    tick(1, 1, 0);
  endtask

  task automatic relock();
    tick(0, 0, 1);
    tick(1, 0, 0);
    tick(1, 1, 0);
    gap(P);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    model_reset();
    n_vec++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", dut_vec(), exp_vec());
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_lock();
    tick(1, 0, 0);
    idle_ticks($urandom_range(5, 200));
    n_vec++;
    if (bus.alive !== 1'b0) begin
      n_err++;
      $display("FAIL sync_not_alive: got %b want 0", bus.alive);
    end
    tick(1, 1, 0);
    n_vec++;
    if (bus.alive !== 1'b1) begin
      n_err++;
      $display("FAIL alive_after_first_pulse: got %b want 1", bus.alive);
    end
    for (int k = 0; k < 3; k++) begin
      gap(P);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL lock_pulse%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (bus.period !== 9'd256 || bus.miss_cnt !== 8'd0 || bus.alive !== 1'b1) begin
      n_err++;
      $display("FAIL lock_steady: period %0d miss %0d alive %b, want 256 0 1",
               bus.period, bus.miss_cnt, bus.alive);
    end
  endtask

  task automatic test_early();
    relock();
    gap(P - 3);
    n_vec++;
    if (bus.early !== 1'b1 || bus.miss_cnt !== 8'd1 || bus.alive !== 1'b0 || bus.period !== 9'd253) begin
      n_err++;
      $display("FAIL early_pulse: early %b miss %0d alive %b period %0d, want 1 1 0 253",
               bus.early, bus.miss_cnt, bus.alive, bus.period);
    end
    gap(P);
    n_vec++;
    if (dut_vec() !== exp_vec() || bus.alive !== 1'b1) begin
      n_err++;
      $display("FAIL early_relock: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_late();
    relock();
    gap(P + TOL);
    n_vec++;
    if (bus.alive !== 1'b1 || bus.late !== 1'b0 || bus.miss_cnt !== 8'd0 || bus.period !== 9'd258) begin
      n_err++;
      $display("FAIL late_edge_good: alive %b late %b miss %0d period %0d, want 1 0 0 258",
               bus.alive, bus.late, bus.miss_cnt, bus.period);
    end
    idle_ticks(P + TOL - 1);
    n_vec++;
    if (bus.late !== 1'b0 || bus.alive !== 1'b1) begin
      n_err++;
      $display("FAIL late_not_yet: late %b alive %b, want 0 1", bus.late, bus.alive);
    end
    tick(1, 0, 0);
    n_vec++;
    if (bus.late !== 1'b1 || bus.miss_cnt !== 8'd1 || bus.alive !== 1'b0) begin
      n_err++;
      $display("FAIL late_timeout: late %b miss %0d alive %b, want 1 1 0",
               bus.late, bus.miss_cnt, bus.alive);
    end
  endtask

  task automatic test_fault();
    relock();
    idle_ticks(3 * (P + TOL) - 1);
    n_vec++;
    if (bus.fault !== 1'b0 || bus.miss_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL fault_not_yet: fault %b miss %0d, want 0 2", bus.fault, bus.miss_cnt);
    end
    tick(1, 0, 0);
    n_vec++;
    if (bus.fault !== 1'b1 || bus.miss_cnt !== 8'd3 || bus.late !== 1'b1) begin
      n_err++;
      $display("FAIL fault_set: fault %b miss %0d late %b, want 1 3 1",
               bus.fault, bus.miss_cnt, bus.late);
    end
    idle_ticks(40);
    tick(1, 1, 0);
    n_vec++;
    if (bus.fault !== 1'b1 || bus.alive !== 1'b0) begin
      n_err++;
      $display("FAIL fault_ignores_hb: fault %b alive %b, want 1 0", bus.fault, bus.alive);
    end
    tick(1, 0, 1);
    n_vec++;
    if (bus.fault !== 1'b0 || bus.miss_cnt !== 8'd0 || bus.late !== 1'b0 || bus.alive !== 1'b0) begin
      n_err++;
      $display("FAIL fault_clear: fault %b miss %0d late %b alive %b, want 0 0 0 0",
               bus.fault, bus.miss_cnt, bus.late, bus.alive);
    end
    gap(17);
    n_vec++;
    if (dut_vec() !== exp_vec() || bus.alive !== 1'b1) begin
      n_err++;
      $display("FAIL fault_relock: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_clear_timeout();
    relock();
    idle_ticks(P + TOL - 1);
    tick(1, 0, 1);
    n_vec++;
    if (bus.miss_cnt !== 8'd0 || bus.late !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL clear_vs_timeout: miss %0d late %b, want 0 0 (vec %h want %h)",
               bus.miss_cnt, bus.late, dut_vec(), exp_vec());
    end
    gap(100);
    n_vec++;
    if (bus.alive !== 1'b1) begin
      n_err++;
      $display("FAIL clear_relock: alive %b want 1", bus.alive);
    end
    tick(0, 0, 0);
    n_vec++;
    if (bus.alive !== 1'b0 || bus.fault !== 1'b0) begin
      n_err++;
      $display("FAIL disable_idle: alive %b fault %b, want 0 0", bus.alive, bus.fault);
    end
  endtask

  task automatic test_random();
    int g;
    bit en, clr;
    relock();
    for (int p = 0; p < 30; p++) begin
      g = $urandom_range(P - 8, P + TOL + 4);
      for (int j = 1; j <= g; j++) begin
        clr = ($urandom_range(0, 299) == 0);
        en  = ($urandom_range(0, 1999) != 0);
        tick(en, j == g, clr);
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
          n_err++;
          $display("FAIL random p%0d j%0d: got %h want %h", p, j, dut_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_async_reset();
    relock();
    idle_ticks(50);
    #3 reset = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if (dut_vec() !== '0) begin
      n_err++;
      $display("FAIL async_reset: got %h want 0", dut_vec());
    end
    @(posedge clk);
    #1 reset = 1'b0;
    tick(1, 0, 0);
    idle_ticks(30);
    tick(1, 1, 0);
    n_vec++;
    if (dut_vec() !== exp_vec() || bus.period !== 9'd31) begin
      n_err++;
      $display("FAIL post_reset_sync: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.hb_in  = 1'b0;
    bus.clear  = 1'b0;
    model_reset();
    test_reset();
    test_lock();
    test_early();
    test_late();
    test_fault();
    test_clear_timeout();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
